// File: rtl/pdp8_console_rx_if.sv
// Consumer-side bundle of the console receiver: character FIFO head, pop handshake and status.
// Latency: none, wires only.
// Backpressure: rx_ready from the consumer pops the FIFO head when rx_valid is high.
interface pdp8_console_rx_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        framing_err;
   logic        overrun;
   logic        err_clr;
   logic [15:0] char_count;

   // Receiver side drives the character stream and status.
   modport master (
      output rx_data,
      output rx_valid,
      output framing_err,
      output overrun,
      output char_count,
      input  rx_ready,
      input  err_clr
   );

   // Consumer side pops characters and clears the sticky errors.
   modport slave (
      input  rx_data,
      input  rx_valid,
      input  framing_err,
      input  overrun,
      input  char_count,
      output rx_ready,
      output err_clr
   );
endinterface

// File: rtl/pdp8_console_rx.sv
// 8N1 serial receiver for the PDP-8 console line, queueing characters in a small FIFO.
// Latency: 2 clk synchronizer, mid-bit sampling, character visible 1 clk after the stop sample.
// Backpressure: none on the serial line; a full FIFO drops the character and sets overrun.
// Optional build macro PDP8_CONSOLE_RX_STRIP8_EN clears bit 7 (ASR-33 mark parity) before queueing.
module pdp8_console_rx #(
   parameter int BIT_CLKS   = 5208,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rxd,
   pdp8_console_rx_if.master      rx_if
);

   localparam int TW = $clog2(BIT_CLKS);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CLKS / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CLKS - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;  // framing error seen, wait for the line to go high

   // ---------------------------------------------------------------
   // Line synchronizer and edge history
   // ---------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Two-flop synchronizer preset to idle-high, plus one more flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          wr_req;
   logic          ferr_evt;
   logic          timer_zero;

   assign timer_zero = (timer_q == '0);

   // Bit timing and sampling: every phase waits for its timer to hit zero, then samples the line.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      wr_req    = 1'b0;
      ferr_evt  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (prev_q && !sync2_q) begin
               timer_d = HALF_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (timer_zero) begin
               if (sync2_q) begin
                  // Start bit did not survive to mid-bit: treat as a glitch.
                  state_d = ST_IDLE;
               end else begin
                  timer_d   = FULL_LOAD;
                  bit_idx_d = 3'd0;
                  state_d   = ST_DATA;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (timer_zero) begin
               shift_d = {sync2_q, shift_q[7:1]};
               timer_d = FULL_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_STOP: begin
            if (timer_zero) begin
               if (sync2_q) begin
                  wr_req  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_evt = 1'b1;
                  state_d  = ST_BREAK;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_BREAK: begin
            // A held-low line (break) must not look like a fresh start bit.
            if (sync2_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // ---------------------------------------------------------------
   // Character FIFO
   // ---------------------------------------------------------------
   logic [7:0]  wr_char;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        wr_ok;
   logic        ovr_evt;

`ifdef PDP8_CONSOLE_RX_STRIP8_EN
   assign wr_char = {1'b0, shift_q[6:0]};
`else
   assign wr_char = shift_q;
`endif

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Pointer and counter next-state; a same-clk pop frees the slot a full-FIFO write needs.
   always_comb begin
      pop      = !fifo_empty && rx_if.rx_ready;
      wr_ok    = wr_req && (!fifo_full || pop);
      ovr_evt  = wr_req && fifo_full && !pop;
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
   end

   // FIFO storage and pointers; storage is cleared so rx_data reads zero out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_char;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // ---------------------------------------------------------------
   // Status: sticky errors and accepted-character count
   // ---------------------------------------------------------------
   logic        framing_q, framing_d;
   logic        overrun_q, overrun_d;
   logic [15:0] char_cnt_q, char_cnt_d;

   // A new error event overrides a simultaneous clear.
   always_comb begin
      framing_d  = ferr_evt ? 1'b1 : (rx_if.err_clr ? 1'b0 : framing_q);
      overrun_d  = ovr_evt  ? 1'b1 : (rx_if.err_clr ? 1'b0 : overrun_q);
      char_cnt_d = char_cnt_q + 16'(wr_ok);
   end

   // Status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         framing_q  <= 1'b0;
         overrun_q  <= 1'b0;
         char_cnt_q <= 16'h0000;
      end else begin
         framing_q  <= framing_d;
         overrun_q  <= overrun_d;
         char_cnt_q <= char_cnt_d;
      end
   end

   assign rx_if.rx_data     = mem_q[rd_ptr_q[AW-1:0]];
   assign rx_if.rx_valid    = !fifo_empty;
   assign rx_if.framing_err = framing_q;
   assign rx_if.overrun     = overrun_q;
   assign rx_if.char_count  = char_cnt_q;

endmodule
